// File: rtl/acc_cpu_core_if.sv
// Instruction-fetch bus between acc_cpu_core (master) and instruction memory (slave).
// Holds the req/ack handshake, the fetch address and the returned instruction word.
interface acc_cpu_core_if #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 4 + ADDR_W
);
   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic               imem_ack;
   logic [INSTR_W-1:0] imem_data;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_data
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_data
   );
endinterface

// File: rtl/acc_cpu_core.sv
// Parametrised single-accumulator CPU: FETCH/EXEC/HALT sequencer, internal register file,
// carry/zero flags and conditional jumps; fetch uses a wait-state tolerant req/ack bus.
module acc_cpu_core #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int REGS   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] initial_addr,
   input  logic              run,
   acc_cpu_core_if.master    imem,
   output logic [DATA_W-1:0] ac,
   output logic [ADDR_W-1:0] pc,
   output logic [3:0]        operation,
   output logic              flag_z,
   output logic              flag_c,
   output logic              halted
);
   localparam int INSTR_W = 4 + ADDR_W;
   localparam int RI_W    = (REGS > 1) ? $clog2(REGS) : 1;

   localparam logic [3:0] OP_NOP = 4'h0, OP_LDI = 4'h1, OP_LD  = 4'h2, OP_ST  = 4'h3,
                          OP_ADD = 4'h4, OP_SUB = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7,
                          OP_XOR = 4'h8, OP_NOT = 4'h9, OP_SHL = 4'hA, OP_SHR = 4'hB,
                          OP_JMP = 4'hC, OP_JZ  = 4'hD, OP_JC  = 4'hE, OP_HLT = 4'hF;

   typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [DATA_W-1:0]  ac_q, ac_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic               z_q, z_d;
   logic               c_q, c_d;
   logic [DATA_W-1:0]  rf_q [REGS];
   logic [DATA_W-1:0]  rf_d [REGS];

   logic [3:0]         opcode;
   logic [ADDR_W-1:0]  operand;
   logic [RI_W-1:0]    ridx;
   logic [DATA_W-1:0]  imm;
   logic [DATA_W-1:0]  rval;
   logic [DATA_W:0]    sum;
   logic [DATA_W:0]    diff;
   logic               fetch_go;
   logic               upd_z;

   assign opcode  = ir_q[INSTR_W-1:ADDR_W];
   assign operand = ir_q[ADDR_W-1:0];
   assign ridx    = operand[RI_W-1:0];
   assign imm     = DATA_W'(operand);
   assign rval    = rf_q[ridx];
   assign sum     = {1'b0, ac_q} + {1'b0, rval};
   // Top bit of the widened difference is the unsigned borrow (ac < R[r]).
   assign diff    = {1'b0, ac_q} - {1'b0, rval};

   // Request is withheld during reset so it first rises in the cycle after rst drops.
   assign imem.imem_req  = (state_q == S_FETCH) && run && !rst;
   assign imem.imem_addr = pc_q;
   assign fetch_go       = imem.imem_req && imem.imem_ack;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ac_d    = ac_q;
      ir_d    = ir_q;
      z_d     = z_q;
      c_d     = c_q;
      rf_d    = rf_q;
      upd_z   = 1'b0;
      case (state_q)
         S_FETCH: begin
            if (fetch_go) begin
               ir_d    = imem.imem_data;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            state_d = S_FETCH;
            pc_d    = pc_q + ADDR_W'(1);
            case (opcode)
               OP_NOP: ;
               OP_LDI: begin ac_d = imm;          upd_z = 1'b1; end
               OP_LD:  begin ac_d = rval;         upd_z = 1'b1; end
               OP_ST:  rf_d[ridx] = ac_q;
               OP_ADD: begin {c_d, ac_d} = sum;   upd_z = 1'b1; end
               OP_SUB: begin
                  ac_d  = diff[DATA_W-1:0];
                  c_d   = diff[DATA_W];
                  upd_z = 1'b1;
               end
               OP_AND: begin ac_d = ac_q & rval;  upd_z = 1'b1; end
               OP_OR:  begin ac_d = ac_q | rval;  upd_z = 1'b1; end
               OP_XOR: begin ac_d = ac_q ^ rval;  upd_z = 1'b1; end
               OP_NOT: begin ac_d = ~ac_q;        upd_z = 1'b1; end
               OP_SHL: begin
                  c_d   = ac_q[DATA_W-1];
                  ac_d  = {ac_q[DATA_W-2:0], 1'b0};
                  upd_z = 1'b1;
               end
               OP_SHR: begin
                  c_d   = ac_q[0];
                  ac_d  = {1'b0, ac_q[DATA_W-1:1]};
                  upd_z = 1'b1;
               end
               OP_JMP: pc_d = operand;
               OP_JZ:  if (z_q) pc_d = operand;
               OP_JC:  if (c_q) pc_d = operand;
               OP_HLT: begin
                  pc_d    = pc_q;
                  state_d = S_HALT;
               end
               default: ;
            endcase
            if (upd_z) z_d = (ac_d == '0);
         end
         S_HALT: ;
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         pc_q    <= initial_addr;
         ac_q    <= '0;
         ir_q    <= '0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
         for (int i = 0; i < REGS; i++) rf_q[i] <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ac_q    <= ac_d;
         ir_q    <= ir_d;
         z_q     <= z_d;
         c_q     <= c_d;
         rf_q    <= rf_d;
      end
   end

   assign ac        = ac_q;
   assign pc        = pc_q;
   assign operation = opcode;
   assign flag_z    = z_q;
   assign flag_c    = c_q;
   assign halted    = (state_q == S_HALT);
endmodule

// File: tb/tb_acc_cpu_core.sv
// Scoreboarded bench for acc_cpu_core: directed programs on an 8/8/16 core and a 16/10/4 core,
// with expected per-fetch architectural state queued up front and checked by monitor processes.
module tb_acc_cpu_core;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, rst1, run, rand_mode;
   logic [7:0] init0;
   logic [9:0] init1;

   acc_cpu_core_if #(.ADDR_W(8),  .INSTR_W(12)) if0 ();
   acc_cpu_core_if #(.ADDR_W(10), .INSTR_W(14)) if1 ();

   logic [7:0]  ac0, pc0;
   logic [3:0]  op0, op1;
   logic        z0, c0, h0, z1, c1, h1;
   logic [15:0] ac1;
   logic [9:0]  pc1;

   logic [11:0] mem0 [256];
   logic [13:0] mem1 [1024];
   int unsigned wait_left = 0;

   acc_cpu_core #(.DATA_W(8), .ADDR_W(8), .REGS(16)) dut0 (
      .clk(clk), .rst(rst), .initial_addr(init0), .run(run), .imem(if0),
      .ac(ac0), .pc(pc0), .operation(op0), .flag_z(z0), .flag_c(c0), .halted(h0)
   );

   acc_cpu_core #(.DATA_W(16), .ADDR_W(10), .REGS(4)) dut1 (
      .clk(clk), .rst(rst1), .initial_addr(init1), .run(1'b1), .imem(if1),
      .ac(ac1), .pc(pc1), .operation(op1), .flag_z(z1), .flag_c(c1), .halted(h1)
   );

   assign if0.imem_data = mem0[if0.imem_addr];
   assign if0.imem_ack  = (wait_left == 0);
   assign if1.imem_data = mem1[if1.imem_addr];
   assign if1.imem_ack  = 1'b1;

   // Wait-state generator: 0..3 cycles before each ack when rand_mode is on.
   always @(posedge clk) begin
      if (!rand_mode)                             wait_left <= 0;
      else if (if0.imem_req && if0.imem_ack)      wait_left <= $urandom_range(0, 3);
      else if (if0.imem_req && wait_left != 0)    wait_left <= wait_left - 1;
   end

   initial begin
      run = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         run = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   typedef struct packed {
      logic [9:0]  addr;
      logic [15:0] acc;
      logic        z;
      logic        c;
      logic [3:0]  op;
   } exp_t;

   exp_t fq0[$], hq0[$], fq1[$], hq1[$];
   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, got, want);
      end
   endtask

   task automatic pf0(input logic [7:0] a, input logic [7:0] acc, input logic z, input logic c);
      fq0.push_back('{addr: {2'b00, a}, acc: {8'h00, acc}, z: z, c: c, op: mem0[a][11:8]});
   endtask
   task automatic ph0(input logic [7:0] a, input logic [7:0] acc, input logic z, input logic c);
      hq0.push_back('{addr: {2'b00, a}, acc: {8'h00, acc}, z: z, c: c, op: 4'h0});
   endtask
   task automatic pf1(input logic [9:0] a, input logic [15:0] acc, input logic z, input logic c);
      fq1.push_back('{addr: a, acc: acc, z: z, c: c, op: 4'h0});
   endtask
   task automatic ph1(input logic [9:0] a, input logic [15:0] acc, input logic z, input logic c);
      hq1.push_back('{addr: a, acc: acc, z: z, c: c, op: 4'h0});
   endtask

   // Monitor for the 8-bit core: fetch trace, operation, halt state and request gating.
   logic       h0_prev = 1'b0, op_pend = 1'b0;
   logic [3:0] op_exp = 4'h0;
   always @(negedge clk) begin : mon0
      exp_t e;
      if (rst) begin
         h0_prev = 1'b0;
         op_pend = 1'b0;
      end else begin
         chk("req_gating0", {31'b0, if0.imem_req && (!run || h0)}, 32'd0);
         if (op_pend) begin
            chk("operation0", {28'b0, op0}, {28'b0, op_exp});
            op_pend = 1'b0;
         end
         if (if0.imem_req && if0.imem_ack) begin
            if (fq0.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL fetch0_unexpected: got fetch at %0h, expected none", if0.imem_addr);
            end else begin
               e = fq0.pop_front();
               chk("fetch_addr0", {24'b0, if0.imem_addr}, {22'b0, e.addr});
               chk("fetch_ac0",   {24'b0, ac0}, {16'b0, e.acc});
               chk("fetch_z0",    {31'b0, z0},  {31'b0, e.z});
               chk("fetch_c0",    {31'b0, c0},  {31'b0, e.c});
               op_exp  = e.op;
               op_pend = 1'b1;
            end
         end
         if (h0 && !h0_prev) begin
            if (hq0.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL halt0_unexpected: got halt at pc %0h, expected none", pc0);
            end else begin
               e = hq0.pop_front();
               chk("halt_pc0", {24'b0, pc0}, {22'b0, e.addr});
               chk("halt_ac0", {24'b0, ac0}, {16'b0, e.acc});
               chk("halt_z0",  {31'b0, z0},  {31'b0, e.z});
               chk("halt_c0",  {31'b0, c0},  {31'b0, e.c});
            end
         end
         h0_prev = h0;
      end
   end

   logic h1_prev = 1'b0;
   always @(negedge clk) begin : mon1
      exp_t e;
      if (rst1) begin
         h1_prev = 1'b0;
      end else begin
         chk("req_gating1", {31'b0, if1.imem_req && h1}, 32'd0);
         if (if1.imem_req && if1.imem_ack) begin
            if (fq1.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL fetch1_unexpected: got fetch at %0h, expected none", if1.imem_addr);
            end else begin
               e = fq1.pop_front();
               chk("fetch_addr1", {22'b0, if1.imem_addr}, {22'b0, e.addr});
               chk("fetch_ac1",   {16'b0, ac1}, {16'b0, e.acc});
               chk("fetch_z1",    {31'b0, z1},  {31'b0, e.z});
               chk("fetch_c1",    {31'b0, c1},  {31'b0, e.c});
            end
         end
         if (h1 && !h1_prev) begin
            if (hq1.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL halt1_unexpected: got halt at pc %0h, expected none", pc1);
            end else begin
               e = hq1.pop_front();
               chk("halt_pc1", {22'b0, pc1}, {22'b0, e.addr});
               chk("halt_ac1", {16'b0, ac1}, {16'b0, e.acc});
               chk("halt_z1",  {31'b0, z1},  {31'b0, e.z});
               chk("halt_c1",  {31'b0, c1},  {31'b0, e.c});
            end
         end
         h1_prev = h1;
      end
   end

   task automatic wait_halt0(input int bound);
      int n = 0;
      while (!h0 && n < bound) begin @(negedge clk); n++; end
      chk("halt0_reached", {31'b0, h0}, 32'd1);
   endtask

   task automatic begin_reset0(input logic [7:0] a);
      @(negedge clk);
      rst   = 1'b1;
      init0 = a;
      for (int i = 0; i < 256; i++) mem0[i] = 12'h000;
   endtask

   task automatic release_reset0();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // LDI FF; ST R2; LDI 1; ADD R2; JC 40 / LDI 0; ST R3; LDI 1; SUB R3; JZ 00; HLT
   task automatic load_p2();
      mem0[8'h20] = 12'h1FF; mem0[8'h21] = 12'h302; mem0[8'h22] = 12'h101;
      mem0[8'h23] = 12'h402; mem0[8'h24] = 12'hE40;
      mem0[8'h40] = 12'h100; mem0[8'h41] = 12'h303; mem0[8'h42] = 12'h101;
      mem0[8'h43] = 12'h503; mem0[8'h44] = 12'hD00; mem0[8'h45] = 12'hF00;
      pf0(8'h20, 8'h00, 0, 0); pf0(8'h21, 8'hFF, 0, 0); pf0(8'h22, 8'hFF, 0, 0);
      pf0(8'h23, 8'h01, 0, 0); pf0(8'h24, 8'h00, 1, 1);
      pf0(8'h40, 8'h00, 1, 1); pf0(8'h41, 8'h00, 1, 1); pf0(8'h42, 8'h00, 1, 1);
      pf0(8'h43, 8'h01, 0, 1); pf0(8'h44, 8'h01, 0, 0); pf0(8'h45, 8'h01, 0, 0);
      ph0(8'h45, 8'h01, 0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1; rst1 = 1'b1; init0 = 8'h10; init1 = 10'h000; rand_mode = 1'b0;
      for (int i = 0; i < 256; i++)  mem0[i] = 12'h000;
      for (int i = 0; i < 1024; i++) mem1[i] = 14'h0000;

      // Program 1: LDI 5; ST R1; LDI 3; ADD R1; HLT from 0x10
      mem0[8'h10] = 12'h105; mem0[8'h11] = 12'h301; mem0[8'h12] = 12'h103;
      mem0[8'h13] = 12'h401; mem0[8'h14] = 12'hF00;
      pf0(8'h10, 8'h00, 0, 0); pf0(8'h11, 8'h05, 0, 0); pf0(8'h12, 8'h05, 0, 0);
      pf0(8'h13, 8'h03, 0, 0); pf0(8'h14, 8'h08, 0, 0);
      ph0(8'h14, 8'h08, 0, 0);
      repeat (3) @(negedge clk);
      chk("rst_pc",     {24'b0, pc0}, 32'h10);
      chk("rst_addr",   {24'b0, if0.imem_addr}, 32'h10);
      chk("rst_ac",     {24'b0, ac0}, 32'h0);
      chk("rst_z",      {31'b0, z0}, 32'h0);
      chk("rst_c",      {31'b0, c0}, 32'h0);
      chk("rst_halted", {31'b0, h0}, 32'h0);
      chk("rst_req",    {31'b0, if0.imem_req}, 32'h0);
      chk("rst_op",     {28'b0, op0}, 32'h0);
      chk("rst_ac1",    {16'b0, ac1}, 32'h0);
      rst = 1'b0;
      n = 0;
      while (!h0 && n < 40) begin @(negedge clk); n++; end
      chk("halt_cycles", n, 32'd10);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("frozen_pc",  {24'b0, pc0}, 32'h14);
         chk("frozen_req", {31'b0, if0.imem_req}, 32'h0);
      end
      chk("p1_drained", fq0.size(), 32'd0);

      // Program 2 with zero wait states, then again with wait states and run toggling
      begin_reset0(8'h20); load_p2(); release_reset0();
      wait_halt0(200);
      chk("p2_drained", fq0.size(), 32'd0);
      begin_reset0(8'h20); load_p2(); rand_mode = 1'b1; release_reset0();
      wait_halt0(1000);
      rand_mode = 1'b0;
      chk("p2r_drained", fq0.size(), 32'd0);

      // PC wrap from 0xFF
      begin_reset0(8'hFF);
      mem0[8'hFF] = 12'h000; mem0[8'h00] = 12'hF00;
      pf0(8'hFF, 8'h00, 0, 0); pf0(8'h00, 8'h00, 0, 0); ph0(8'h00, 8'h00, 0, 0);
      release_reset0();
      wait_halt0(100);

      // Reset during EXEC of ST R4, then restart at 0x60 and read R4 back
      begin_reset0(8'h50);
      mem0[8'h50] = 12'h107; mem0[8'h51] = 12'h304; mem0[8'h52] = 12'hF00;
      mem0[8'h60] = 12'h204; mem0[8'h61] = 12'hF00;
      pf0(8'h50, 8'h00, 0, 0); pf0(8'h51, 8'h07, 0, 0);
      release_reset0();
      n = 0;
      while (!(if0.imem_req && if0.imem_ack && if0.imem_addr == 8'h51) && n < 20) begin
         @(negedge clk); n++;
      end
      chk("abort_fetch_addr", {24'b0, if0.imem_addr}, 32'h51);
      @(negedge clk);
      chk("abort_in_st", {28'b0, op0}, 32'h3);
      rst = 1'b1; init0 = 8'h60;
      pf0(8'h60, 8'h00, 0, 0); pf0(8'h61, 8'h00, 1, 0); ph0(8'h61, 8'h00, 1, 0);
      @(negedge clk);
      chk("abort_pc", {24'b0, pc0}, 32'h60);
      chk("abort_ac", {24'b0, ac0}, 32'h0);
      chk("abort_op", {28'b0, op0}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      wait_halt0(100);
      chk("p4_drained", fq0.size(), 32'd0);

      // 16-bit / 10-bit / 4-register core: LDI 3FF; ST R5; LDI 0; LD R1; NOT; SHL; HLT
      mem1[0] = 14'h07FF; mem1[1] = 14'h0C05; mem1[2] = 14'h0400; mem1[3] = 14'h0801;
      mem1[4] = 14'h2400; mem1[5] = 14'h2800; mem1[6] = 14'h3C00;
      pf1(10'd0, 16'h0000, 0, 0); pf1(10'd1, 16'h03FF, 0, 0); pf1(10'd2, 16'h03FF, 0, 0);
      pf1(10'd3, 16'h0000, 1, 0); pf1(10'd4, 16'h03FF, 0, 0); pf1(10'd5, 16'hFC00, 0, 0);
      pf1(10'd6, 16'hF800, 0, 1);
      ph1(10'd6, 16'hF800, 0, 1);
      @(negedge clk);
      rst1 = 1'b0;
      n = 0;
      while (!h1 && n < 100) begin @(negedge clk); n++; end
      chk("halt1_reached", {31'b0, h1}, 32'd1);
      @(negedge clk);
      chk("p5_drained", fq1.size(), 32'd0);
      chk("halts_drained", hq0.size() + hq1.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/acc_cpu_core.md
# acc_cpu_core

Parametrised accumulator CPU core, the next generation of the team's 8-bit single-accumulator processor. Data width, address width and register-file depth are generalised. Instruction fetch goes through a req/ack handshake that tolerates wait states, and the core adds carry/zero flags, conditional jumps, a run/stall input and a halt state. It sits between an external instruction memory and the system top; the register file is internal.

## Interface
Parameters:
- DATA_W, 8, accumulator/register/ALU width (≥4)
- ADDR_W, 8, program-counter and instruction-address width (≥4)
- REGS, 16, register-file entries (power of two, 2..2^ADDR_W); RI_W = log2(REGS)
- INSTR_W, derived = 4 + ADDR_W; bits [INSTR_W-1:ADDR_W] opcode, [ADDR_W-1:0] operand

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- initial_addr  in  ADDR_W  PC load value, sampled while rst=1
- run  in  1  1 = core may start a new fetch; 0 = stall in FETCH
- imem_req  out  1  fetch request, held until acknowledged
- imem_addr  out  ADDR_W  fetch address (= pc)
- imem_ack  in  1  instruction valid on imem_data this cycle
- imem_data  in  INSTR_W  instruction word
- ac  out  DATA_W  accumulator
- pc  out  ADDR_W  program counter
- operation  out  4  opcode of the instruction in IR
- flag_z  out  1  zero flag
- flag_c  out  1  carry/borrow flag
- halted  out  1  core in HALT state

## Operation
- States: FETCH, EXEC, HALT.
- Reset values: state=FETCH, pc=initial_addr, ac=0, IR=0 (operation=0), flag_z=0, flag_c=0, halted=0, imem_req=0, all registers 0.
- FETCH:
  - imem_req = run; imem_addr = pc.
  - On req&ack, latch imem_data into IR and go to EXEC.
  - If run=0, no request and the core stays in FETCH.
  - If run drops while a request is outstanding, imem_req deasserts and no fetch occurs.
- EXEC (one cycle): execute the IR, then go to FETCH. HLT goes to HALT instead.
- Default pc update is pc+1 mod 2^ADDR_W.
- Register index r = operand[RI_W-1:0]. Immediate = operand zero-extended or truncated to DATA_W.
- Opcodes:
  - 0 NOP.
  - 1 LDI: ac=imm.
  - 2 LD: ac=R[r].
  - 3 ST: R[r]=ac.
  - 4 ADD: {c,ac}=ac+R[r].
  - 5 SUB: ac=ac-R[r], c=borrow (ac<R[r] unsigned).
  - 6 AND, 7 OR, 8 XOR: with R[r].
  - 9 NOT: ac=~ac.
  - A SHL: c=ac[msb], ac<<=1.
  - B SHR: c=ac[0], ac>>=1 (logical).
  - C JMP: pc=operand.
  - D JZ: pc=operand if flag_z, else pc+1.
  - E JC: same as JZ using flag_c.
  - F HLT: pc unchanged.
- Flag updates:
  - flag_z is set to (new ac==0) by opcodes 1,2,4–B.
  - flag_c is written only by 4,5,A,B.
  - Other opcodes leave the flags unchanged.
- HALT: halted=1, imem_req=0, all state frozen. Exit only through rst.
- rst mid-fetch or mid-EXEC aborts the operation; the instruction has no architectural effect.

## Timing
- Minimum 2 cycles per instruction: FETCH with ack in the same cycle as req, then EXEC.
- Each wait state adds 1 cycle; there is no timeout.
- imem_req is combinational from state and run; it asserts in the first FETCH cycle after rst deasserts.
- ac, flags, pc and the register file update on the clock edge that ends EXEC.
- operation is valid from the cycle after ack until the next ack.
- JZ/JC test the flags as they stand at EXEC entry, i.e. the results of prior instructions.
- ST followed by LD of the same register returns the stored value; there is no hazard because execution is sequential.
- PC wraps from 2^ADDR_W-1 to 0 on both increment and fall-through.
- halted rises the cycle after HLT's EXEC.

## Test plan
- Reset with initial_addr=0x10, ack always 1 → first imem_addr=0x10; ac=0, flags=0, halted=0.
- Program LDI 5; ST R1; LDI 3; ADD R1; HLT, ack always 1 (DATA_W=8):
  - ac=8, z=0, c=0.
  - halted=1 after exactly 10 cycles from reset release.
  - pc frozen on the HLT address.
- LDI 0xFF; ST R2; LDI 1; ADD R2 → ac=0, c=1, z=1; next JC 0x40 → imem_addr=0x40. Then LDI 0; ST R3; LDI 1; SUB R3 → c=0, z=0; JZ 0x00 falls through.
- Random 0–3 wait states on imem_ack and run toggled during FETCH:
  - architectural results identical to the zero-wait run;
  - imem_req never asserted while run=0 or halted=1.
- PC wrap: initial_addr=0xFF with NOP → next fetch at 0x00. Assert rst during an EXEC of ST R4 → R4 unchanged, pc=initial_addr.
- Parameter sweep DATA_W=16, ADDR_W=10, REGS=4: LDI 0x3FF gives ac=0x03FF; ST R5 aliases to R1; SHL carries out bit 15.
